id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the ALU in the pipelined MIPS datapath. It registers the decoded instruction's operands, immediate, ALU control code and destination/control bits. It drives the ALU `A`, `B` and `alu_cs` inputs through forwarding muxes fed from the MEM and WB stages, and raises a load-use stall back to fetch/decode.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `REG_W`, 5, register-index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  decode holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  REG_W  source/dest register indices
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  already sign/zero-extended immediate
- `id_alu_cs`  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 ZERO
- `id_use_imm`  in  1  B operand = immediate
- `id_reg_dst`  in  1  dest = rd (1) or rt (0)
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits
- `hold`  in  1  downstream not ready; freeze stage
- `flush`  in  1  kill the instruction in the stage (branch taken)
- `mem_reg_write`  in  1, `mem_rd`  in  REG_W, `mem_result`  in  DATA_W  EX/MEM forwarding source
- `wb_reg_write`  in  1, `wb_rd`  in  REG_W, `wb_result`  in  DATA_W  MEM/WB forwarding source
- `ex_valid`  out  1  stage holds a real instruction
- `ex_a`, `ex_b`  out  DATA_W  ALU operands
- `ex_alu_cs`  out  3  ALU control
- `ex_store_data`  out  DATA_W  forwarded rt value for stores
- `ex_dest`  out  REG_W  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  gated by `ex_valid`
- `id_stall`  out  1  load-use hazard; decode must hold

## Operation
- Registered fields: valid, rs, rt, rs_data, rt_data, imm, alu_cs, use_imm, dest (rd or rt selected at capture), reg_write, mem_read, mem_write.
- Edge update priority: reset > `flush` > `hold` > `id_stall` > capture.
  - `flush`: valid<=0; all control bits cleared.
  - `hold`: all fields kept, plus operand refresh.
  - `id_stall`: bubble inserted (valid<=0, controls 0).
  - Otherwise: capture the ID inputs; if `id_valid`=0, capture a bubble.
- Operand refresh while held: if `wb_reg_write` and `wb_rd`!=0 and `wb_rd`==stored rs (resp. rt), stored rs_data (resp. rt_data) <= `wb_result`. This prevents losing a result that retires during the hold.
- Forwarding, combinational per operand (rs shown; rt identical):
  - if `mem_reg_write` and `mem_rd`!=0 and `mem_rd`==rs: `mem_result`
  - elif `wb_reg_write` and `wb_rd`!=0 and `wb_rd`==rs: `wb_result`
  - else stored rs_data
  - MEM has priority over WB. Register 0 is never forwarded.
- Output mapping:
  - `ex_a` = fwd(rs)
  - `ex_b` = use_imm ? imm : fwd(rt)
  - `ex_store_data` = fwd(rt)
  - `ex_alu_cs` = stored alu_cs; equals 000 when a bubble is captured
  - `ex_reg_write`/`ex_mem_read`/`ex_mem_write` = valid & stored bit
- Load-use: `id_stall` = valid & mem_read & dest!=0 & `id_valid` & (`id_rs`==dest | `id_rt`==dest). Combinational.
- No arithmetic in block; all data paths pass DATA_W bits unchanged.

## Timing
- Latency: 1 cycle from ID inputs at edge N to `ex_*` valid after edge N.
- Forwarding path is combinational, so same-cycle MEM/WB changes appear on `ex_a`/`ex_b` in that cycle.
- Reset (async, immediate on `rst_n`=0): all registers 0, so `ex_valid`=0, `ex_a`=0, `ex_b`=0, `ex_store_data`=0, `ex_alu_cs`=000, `ex_dest`=0, all control outputs 0, `id_stall`=0. Reset mid-operation discards the in-flight instruction.
- `flush` and `hold` in the same cycle: flush wins.
- `hold` and `id_stall` in the same cycle: hold wins. `id_stall` stays asserted, decode keeps holding.
- A load-use stall lasts exactly one cycle. After the bubble, the load sits in MEM and its result forwards via `mem_result`/`wb_result`.

## Test plan
- Reset mid-operation: capture ADD (rs=1 data 30, rt=2 data 25), then drop `rst_n` between edges → all outputs 0 immediately, `ex_valid`=0 until the next capture after release.
- Basic capture: rs=1/30, rt=2/25, alu_cs=010, use_imm=0 → next cycle `ex_a`=30, `ex_b`=25, `ex_alu_cs`=010, `ex_valid`=1. Repeat with use_imm=1, imm=0xFFFFFFFC → `ex_b`=0xFFFFFFFC, `ex_store_data`=25.
- Forwarding priority, stored rs=3:
  - mem_rd=3/7 and wb_rd=3/9 both writing → `ex_a`=7
  - `mem_reg_write`=0 → 9
  - rs=0 with mem_rd=0 writing 0x1234 → `ex_a`=stored data
- Load-use: stage holds LW dest=5; ID instr rs=5 → `id_stall`=1; next edge `ex_valid`=0; following edge captures the instruction, `id_stall`=0.
- Hold refresh: stored rt=4, data 0; `hold`=1 for 3 cycles; WB writes r4=0x55 in cycle 2 only → after release `ex_b`=0x55 with no forwarding active.
- Flush vs hold: valid instruction in stage, `flush`=`hold`=1 → next cycle `ex_valid`=0, `ex_reg_write`=0, `ex_mem_write`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Operands are forwarded from MEM/WB
// and a load-use stall is raised back to decode.
module id_ex_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] stored,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd
);
  // MEM is the younger producer, so it beats WB; r0 is hard-wired zero.
  always_comb begin
    fwd = stored;
    if (mem_reg_write && mem_rd != '0 && mem_rd == src)
      fwd = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == src)
      fwd = wb_result;
  end
endmodule

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_cs,
  input  logic              id_use_imm,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              hold,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_alu_cs,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              id_stall
);
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_cs;
    logic              use_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } stage_t;

  stage_t st, cap;
  logic   wb_hit_rs, wb_hit_rt;
  logic [1:0][REG_W-1:0]  src;
  logic [1:0][DATA_W-1:0] stored, fwd;

  always_comb begin
    cap           = '0;
    cap.valid     = 1'b1;
    cap.rs        = id_rs;
    cap.rt        = id_rt;
    cap.dest      = id_reg_dst ? id_rd : id_rt;
    cap.rs_data   = id_rs_data;
    cap.rt_data   = id_rt_data;
    cap.imm       = id_imm;
    cap.alu_cs    = id_alu_cs;
    cap.use_imm   = id_use_imm;
    cap.reg_write = id_reg_write;
    cap.mem_read  = id_mem_read;
    cap.mem_write = id_mem_write;
  end

  assign id_stall = st.valid & st.mem_read & (st.dest != '0) & id_valid &
                    ((id_rs == st.dest) | (id_rt == st.dest));

  // A result retiring from WB while held would otherwise be lost once WB moves on.
  assign wb_hit_rs = wb_reg_write && wb_rd != '0 && wb_rd == st.rs;
  assign wb_hit_rt = wb_reg_write && wb_rd != '0 && wb_rd == st.rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else if (flush) begin
      st.valid     <= 1'b0;
      st.reg_write <= 1'b0;
      st.mem_read  <= 1'b0;
      st.mem_write <= 1'b0;
    end else if (hold) begin
      if (wb_hit_rs) st.rs_data <= wb_result;
      if (wb_hit_rt) st.rt_data <= wb_result;
    end else if (id_stall || !id_valid) begin
      st <= '0;
    end else begin
      st <= cap;
    end
  end

  assign src    = {st.rt, st.rs};
  assign stored = {st.rt_data, st.rs_data};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    id_ex_fwd #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd (
      .src          (src[i]),
      .stored       (stored[i]),
      .mem_reg_write(mem_reg_write),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .fwd          (fwd[i])
    );
  end

  assign ex_valid      = st.valid;
  assign ex_a          = fwd[0];
  assign ex_b          = st.use_imm ? st.imm : fwd[1];
  assign ex_store_data = fwd[1];
  assign ex_alu_cs     = st.alu_cs;
  assign ex_dest       = st.dest;
  assign ex_reg_write  = st.valid & st.reg_write;
  assign ex_mem_read   = st.valid & st.mem_read;
  assign ex_mem_write  = st.valid & st.mem_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expectations, a negedge
// monitor pops and compares them against the stage outputs.
module tb_id_ex_stage;
  logic        clk, rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_cs;
  logic        id_use_imm, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        hold, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_stall;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_cs;
  logic [4:0]  ex_dest;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_cs(id_alu_cs), .id_use_imm(id_use_imm), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .hold(hold), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_cs(ex_alu_cs),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .id_stall(id_stall)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] a, b, sd;
    logic [2:0]  cs;
    logic [4:0]  dest;
    logic        rw, mr, mw, st;
    bit          chk_data;  // a, b, store data, dest
    bit          chk_cs;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e = q.pop_front();
      bad = (ex_valid !== e.v) || (ex_reg_write !== e.rw) || (ex_mem_read !== e.mr) ||
            (ex_mem_write !== e.mw) || (id_stall !== e.st);
      if (e.chk_cs && ex_alu_cs !== e.cs) bad = 1'b1;
      if (e.chk_data && (ex_a !== e.a || ex_b !== e.b || ex_store_data !== e.sd ||
                         ex_dest !== e.dest)) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got v=%b a=%h b=%h sd=%h cs=%0d dest=%0d rw/mr/mw=%b%b%b stall=%b; expected v=%b a=%h b=%h sd=%h cs=%0d dest=%0d rw/mr/mw=%b%b%b stall=%b (data chk %0d, cs chk %0d)",
                 e.name, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_cs, ex_dest,
                 ex_reg_write, ex_mem_read, ex_mem_write, id_stall,
                 e.v, e.a, e.b, e.sd, e.cs, e.dest, e.rw, e.mr, e.mw, e.st,
                 e.chk_data, e.chk_cs);
      end
    end
  end

  task automatic expect_out(input string name, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] sd, input logic [2:0] cs,
                            input logic [4:0] dest, input logic rw, input logic mr,
                            input logic mw, input logic st, input bit chk_data,
                            input bit chk_cs);
    exp_t e;
    e.name = name; e.v = v; e.a = a; e.b = b; e.sd = sd; e.cs = cs; e.dest = dest;
    e.rw = rw; e.mr = mr; e.mw = mw; e.st = st; e.chk_data = chk_data; e.chk_cs = chk_cs;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_cs = 0;
    id_use_imm = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic fwd_off();
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic [2:0] cs,
                        input logic ui, input logic rdst, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_imm = imm; id_alu_cs = cs; id_use_imm = ui; id_reg_dst = rdst; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  // Capture one instruction at the next edge, then return decode to idle.
  task automatic cap(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                     input logic [31:0] rtd, input logic [31:0] imm, input logic [2:0] cs,
                     input logic ui, input logic rdst, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic mw);
    set_id(rs, rsd, rt, rtd, imm, cs, ui, rdst, rd, rw, mr, mw);
    step();
    id_idle();
  endtask

  initial begin
    rst_n = 0; hold = 0; flush = 0;
    id_idle();
    fwd_off();
    step();
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    rst_n = 1;

    // Basic capture, register then immediate B operand
    cap(1, 30, 2, 25, 0, 3'b010, 0, 1, 3, 1, 0, 0);
    expect_out("cap_add", 1, 30, 25, 25, 3'b010, 3, 1, 0, 0, 0, 1, 1);
    cap(1, 30, 2, 25, 32'hFFFF_FFFC, 3'b010, 1, 0, 3, 1, 0, 0);
    expect_out("cap_imm", 1, 30, 32'hFFFF_FFFC, 25, 3'b010, 2, 1, 0, 0, 0, 1, 1);

    // Reset between edges while an instruction is held
    cap(1, 30, 2, 25, 0, 3'b010, 0, 1, 3, 1, 0, 0);
    expect_out("pre_rst", 1, 30, 25, 25, 3'b010, 3, 1, 0, 0, 0, 1, 1);
    hold = 1;
    step();
    rst_n = 0;
    expect_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    rst_n = 1; hold = 0;
    step();
    expect_out("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Forwarding priority
    cap(3, 32'h11, 6, 32'h22, 0, 3'b001, 0, 1, 8, 1, 0, 0);
    mem_reg_write = 1; mem_rd = 3; mem_result = 7;
    wb_reg_write = 1; wb_rd = 3; wb_result = 9;
    expect_out("fwd_mem_over_wb", 1, 7, 32'h22, 32'h22, 3'b001, 8, 1, 0, 0, 0, 1, 1);
    step(); fwd_off();
    cap(3, 32'h11, 6, 32'h22, 0, 3'b001, 0, 1, 8, 1, 0, 0);
    mem_reg_write = 0; mem_rd = 3; mem_result = 7;
    wb_reg_write = 1; wb_rd = 3; wb_result = 9;
    expect_out("fwd_wb", 1, 9, 32'h22, 32'h22, 3'b001, 8, 1, 0, 0, 0, 1, 1);
    step(); fwd_off();
    cap(3, 32'h11, 6, 32'h22, 0, 3'b001, 0, 1, 8, 1, 0, 0);
    mem_reg_write = 1; mem_rd = 6; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 6; wb_result = 32'hBB;
    expect_out("fwd_rt", 1, 32'h11, 32'hAA, 32'hAA, 3'b001, 8, 1, 0, 0, 0, 1, 1);
    step(); fwd_off();
    cap(0, 32'h5A, 6, 32'h22, 0, 3'b001, 0, 1, 8, 1, 0, 0);
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h1234;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'h99;
    expect_out("fwd_r0", 1, 32'h5A, 32'h22, 32'h22, 3'b001, 8, 1, 0, 0, 0, 1, 1);
    step(); fwd_off();

    // Load-use: LW r5 in stage, dependent instruction in decode
    cap(1, 32'h100, 5, 0, 4, 3'b010, 1, 0, 0, 1, 1, 0);
    set_id(5, 0, 7, 32'h77, 0, 3'b011, 0, 1, 9, 1, 0, 0);
    expect_out("lu_stall", 1, 32'h100, 4, 0, 3'b010, 5, 1, 1, 0, 1, 1, 1);
    step();
    expect_out("lu_bubble", 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
    step();
    id_idle();
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'hDEAD;
    expect_out("lu_cap", 1, 32'hDEAD, 32'h77, 32'h77, 3'b011, 9, 1, 0, 0, 0, 1, 1);
    step(); fwd_off();

    // Hold with a WB write of the held rt in the middle cycle only
    cap(2, 32'h10, 4, 0, 0, 3'b000, 0, 1, 10, 1, 0, 0);
    hold = 1;
    expect_out("hold_c0", 1, 32'h10, 0, 0, 3'b000, 10, 1, 0, 0, 0, 1, 1);
    step();
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'h55;
    expect_out("hold_fwd", 1, 32'h10, 32'h55, 32'h55, 3'b000, 10, 1, 0, 0, 0, 1, 1);
    step();
    fwd_off();
    expect_out("hold_ref", 1, 32'h10, 32'h55, 32'h55, 3'b000, 10, 1, 0, 0, 0, 1, 1);
    step();
    hold = 0;
    expect_out("hold_rel", 1, 32'h10, 32'h55, 32'h55, 3'b000, 10, 1, 0, 0, 0, 1, 1);
    step();

    // Flush beats hold
    cap(1, 1, 2, 2, 0, 3'b010, 0, 1, 3, 1, 0, 1);
    expect_out("pre_flush", 1, 1, 2, 2, 3'b010, 3, 1, 0, 1, 0, 1, 1);
    flush = 1; hold = 1;
    step();
    flush = 0; hold = 0;
    expect_out("flush_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
